// File: rtl/gpio_ext_pkg.sv
// Shared GPIO register map: byte offsets decoded from addr_i[7:0].
package gpio_ext_pkg;

  localparam logic [7:0] GPIO_DIR    = 8'h00;
  localparam logic [7:0] GPIO_OUT    = 8'h04;
  localparam logic [7:0] GPIO_IN     = 8'h08;
  localparam logic [7:0] GPIO_IE     = 8'h0C;
  localparam logic [7:0] GPIO_ITYPE  = 8'h10;
  localparam logic [7:0] GPIO_IPOL   = 8'h14;
  localparam logic [7:0] GPIO_IP     = 8'h18;
  localparam logic [7:0] GPIO_OUTSET = 8'h1C;
  localparam logic [7:0] GPIO_OUTCLR = 8'h20;

endpackage

// File: rtl/gpio_sync.sv
// One-bit input synchroniser with a history flop for edge detection.
module gpio_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_o = r_sync[SYNC_STAGES-1];
  assign rise_o = sync_o & ~r_prev;
  assign fall_o = ~sync_o & r_prev;

endmodule

// File: rtl/gpio_ext.sv
// GPIO block: direction/output registers, synchronised inputs and
// per-pin level/edge interrupts with a single level interrupt line.
module gpio_ext
  import gpio_ext_pkg::*;
#(
  parameter int unsigned NUM_IO      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic [NUM_IO-1:0] io_pin_i,
  output logic [NUM_IO-1:0] io_out_o,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic              int_sig_o
);

  localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [NUM_IO-1:0] r_dir, r_out, r_ie, r_itype, r_ipol, r_ip;
  logic [2:0]        r_warm;

  logic [NUM_IO-1:0] w_sync, w_rise, w_fall;
  logic [NUM_IO-1:0] w_wdata, w_clr, w_edge, w_lvl, w_ip_d, w_rd;
  logic [7:0]        w_off;
  logic              w_cfg_wr, w_edge_en;
  logic              w_unused;

  for (genvar g = 0; g < NUM_IO; g++) begin : g_sync
    gpio_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .pin_i (io_pin_i[g]),
      .sync_o(w_sync[g]),
      .rise_o(w_rise[g]),
      .fall_o(w_fall[g])
    );
  end

  assign w_off     = addr_i[7:0];
  assign w_wdata   = data_i[NUM_IO-1:0];
  assign w_unused  = ^{addr_i[31:8], data_i};
  assign w_edge_en = (r_warm == WARM_CYCLES);

  // A config write suppresses new IP sets for that cycle only.
  assign w_cfg_wr = we_i && ((w_off == GPIO_ITYPE) || (w_off == GPIO_IPOL));
  assign w_clr    = (we_i && (w_off == GPIO_IP)) ? w_wdata : '0;
  assign w_edge   = (w_edge_en && !w_cfg_wr) ? ((w_rise & r_ipol) | (w_fall & ~r_ipol)) : '0;
  assign w_lvl    = ~(w_sync ^ r_ipol);

  // Edge bits are sticky with set beating W1C; level bits follow the pin.
  assign w_ip_d = (r_itype & ((r_ip & ~w_clr) | w_edge))
                | (~r_itype & (w_cfg_wr ? (r_ip & w_lvl) : w_lvl));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir   <= '0;
      r_out   <= '0;
      r_ie    <= '0;
      r_itype <= '0;
      r_ipol  <= '0;
      r_ip    <= '0;
      r_warm  <= '0;
    end else begin
      r_ip <= w_ip_d;
      if (r_warm != WARM_CYCLES) begin
        r_warm <= r_warm + 3'd1;
      end
      if (we_i) begin
        case (w_off)
          GPIO_DIR:    r_dir   <= w_wdata;
          GPIO_OUT:    r_out   <= w_wdata;
          GPIO_IE:     r_ie    <= w_wdata;
          GPIO_ITYPE:  r_itype <= w_wdata;
          GPIO_IPOL:   r_ipol  <= w_wdata;
          GPIO_OUTSET: r_out   <= r_out | w_wdata;
          GPIO_OUTCLR: r_out   <= r_out & ~w_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (w_off)
      GPIO_DIR:   w_rd = r_dir;
      GPIO_OUT:   w_rd = r_out;
      GPIO_IN:    w_rd = w_sync;
      GPIO_IE:    w_rd = r_ie;
      GPIO_ITYPE: w_rd = r_itype;
      GPIO_IPOL:  w_rd = r_ipol;
      GPIO_IP:    w_rd = r_ip;
      default:    w_rd = '0;
    endcase
  end

  assign data_o    = 32'(w_rd);
  assign io_oe_o   = r_dir;
  assign io_out_o  = r_out;
  assign int_sig_o = |(r_ip & r_ie);

endmodule

// File: tb/tb_gpio_ext.sv
// Directed bench for gpio_ext: default 16-pin build plus an 8-pin build on the same bus.
module tb_gpio_ext;

  localparam logic [7:0] A_DIR    = 8'h00;
  localparam logic [7:0] A_OUT    = 8'h04;
  localparam logic [7:0] A_IN     = 8'h08;
  localparam logic [7:0] A_IE     = 8'h0C;
  localparam logic [7:0] A_ITYPE  = 8'h10;
  localparam logic [7:0] A_IPOL   = 8'h14;
  localparam logic [7:0] A_IP     = 8'h18;
  localparam logic [7:0] A_OUTSET = 8'h1C;
  localparam logic [7:0] A_OUTCLR = 8'h20;
  localparam logic [7:0] A_NONE   = 8'h24;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [15:0] io_pin_i = '0;
  logic [31:0] data_o, data8_o;
  logic [15:0] io_out_o, io_oe_o;
  logic [7:0]  io_out8_o, io_oe8_o;
  logic        int_sig_o, int_sig8_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] d16, d8;

  gpio_ext u_dut (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .io_pin_i (io_pin_i),
    .io_out_o (io_out_o),
    .io_oe_o  (io_oe_o),
    .int_sig_o(int_sig_o)
  );

  gpio_ext #(
    .NUM_IO(8)
  ) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data8_o),
    .io_pin_i (io_pin_i[7:0]),
    .io_out_o (io_out8_o),
    .io_oe_o  (io_oe8_o),
    .int_sig_o(int_sig8_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; the write lands on the following rising edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we_i   = 1'b1;
    addr_i = {24'h0, a};
    data_i = d;
    @(negedge clk);
    we_i   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r16, output logic [31:0] r8);
    addr_i = {24'h0, a};
    #1;
    r16 = data_o;
    r8  = data8_o;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_oe", 32'(io_oe_o), 32'h0);
    check_eq("rst_out", 32'(io_out_o), 32'h0);
    check_eq("rst_int", 32'(int_sig_o), 32'h0);
    rd(A_IP, d16, d8);
    check_eq("rst_ip", d16, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    wr(A_ITYPE, 32'hFFFF);
    wr(A_IPOL, 32'hFFFF);
    wr(A_IP, 32'hFFFF);
    rd(A_IP, d16, d8);
    check_eq("init_ip", d16, 32'h0);
    rd(A_IN, d16, d8);
    check_eq("init_in", d16, 32'h0);

    @(negedge clk);
    wr(A_DIR, 32'h00FF);
    check_eq("dir_oe", 32'(io_oe_o), 32'h00FF);
    wr(A_OUT, 32'h00A5);
    check_eq("out_pad", 32'(io_out_o), 32'h00A5);
    wr(A_OUTSET, 32'h0100);
    rd(A_OUT, d16, d8);
    check_eq("outset", d16, 32'h01A5);
    @(negedge clk);
    wr(A_OUTCLR, 32'h0005);
    rd(A_OUT, d16, d8);
    check_eq("outclr", d16, 32'h01A0);
    check_eq("outclr_pad", 32'(io_out_o), 32'h01A0);
    rd(A_OUTSET, d16, d8);
    check_eq("outset_rd0", d16, 32'h0);

    @(negedge clk);
    wr(A_IE, 32'h0008);
    io_pin_i[3] = 1'b1;
    @(negedge clk);
    rd(A_IN, d16, d8);
    check_eq("in_1cyc", d16, 32'h0);
    @(negedge clk);
    rd(A_IN, d16, d8);
    check_eq("in_2cyc", d16, 32'h0008);
    rd(A_IP, d16, d8);
    check_eq("ip_2cyc", d16, 32'h0);
    @(negedge clk);
    rd(A_IP, d16, d8);
    check_eq("ip_3cyc", d16, 32'h0008);
    check_eq("int_set", 32'(int_sig_o), 32'h1);
    @(negedge clk);
    wr(A_IP, 32'h0008);
    rd(A_IP, d16, d8);
    check_eq("ip_w1c", d16, 32'h0);
    check_eq("int_clr", 32'(int_sig_o), 32'h0);

    io_pin_i[3] = 1'b0;
    repeat (4) @(negedge clk);
    rd(A_IP, d16, d8);
    check_eq("fall_ignored", d16, 32'h0);
    io_pin_i[3] = 1'b1;
    repeat (2) @(negedge clk);
    wr(A_IP, 32'h0008);
    rd(A_IP, d16, d8);
    check_eq("set_wins", d16, 32'h0008);
    @(negedge clk);
    wr(A_IP, 32'h0008);
    rd(A_IP, d16, d8);
    check_eq("set_wins_clr", d16, 32'h0);

    @(negedge clk);
    wr(A_ITYPE, 32'hFFDF);
    wr(A_IPOL, 32'hFFDF);
    rd(A_IP, d16, d8);
    check_eq("cfg_wr_block", d16, 32'h0);
    @(negedge clk);
    rd(A_IP, d16, d8);
    check_eq("lvl_set", d16, 32'h0020);
    check_eq("lvl_int_masked", 32'(int_sig_o), 32'h0);
    @(negedge clk);
    wr(A_IP, 32'h0020);
    rd(A_IP, d16, d8);
    check_eq("lvl_w1c_ign", d16, 32'h0020);
    io_pin_i[5] = 1'b1;
    repeat (2) @(negedge clk);
    rd(A_IP, d16, d8);
    check_eq("lvl_2cyc", d16, 32'h0020);
    @(negedge clk);
    rd(A_IP, d16, d8);
    check_eq("lvl_3cyc", d16, 32'h0);

    @(negedge clk);
    wr(A_IN, 32'h0);
    rd(A_IN, d16, d8);
    check_eq("in_ro", d16, 32'h0028);
    rd(A_NONE, d16, d8);
    check_eq("unmapped16", d16, 32'h0);
    check_eq("unmapped8", d8, 32'h0);
    @(negedge clk);
    wr(A_NONE, 32'hFFFF);
    rd(A_DIR, d16, d8);
    check_eq("unmapped_wr", d16, 32'h00FF);
    @(negedge clk);
    wr(A_DIR, 32'hFFFF_FFFF);
    rd(A_DIR, d16, d8);
    check_eq("dir_mask16", d16, 32'h0000_FFFF);
    check_eq("dir_mask8", d8, 32'h0000_00FF);
    check_eq("oe8", 32'(io_oe8_o), 32'h00FF);

    // Reset while pins are mid-transition, then release with pins high.
    @(negedge clk);
    rst = 1'b0;
    io_pin_i = 16'hFFFF;
    @(negedge clk);
    check_eq("rst2_oe", 32'(io_oe_o), 32'h0);
    check_eq("rst2_int", 32'(int_sig_o), 32'h0);
    rd(A_IN, d16, d8);
    check_eq("rst2_in", d16, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    wr(A_ITYPE, 32'hFFFF);
    wr(A_IPOL, 32'hFFFF);
    for (int i = 0; i < 10; i++) begin
      rd(A_IP, d16, d8);
      check_eq("warm_ip16", d16, 32'h0);
      check_eq("warm_ip8", d8, 32'h0);
      @(negedge clk);
    end
    rd(A_IN, d16, d8);
    check_eq("warm_in", d16, 32'hFFFF);

    io_pin_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    io_pin_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    rd(A_IP, d16, d8);
    check_eq("post_warm_edge", d16, 32'h0001);
    check_eq("post_warm_edge8", d8, 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_ext.md
GPIO_EXT -- requirements
Module: gpio_ext

Interface
REQ-001 SHALL have parameter NUM_IO, default 16: GPIO pin count, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port we_i, input, 1: bus write strobe.
REQ-006 SHALL have port addr_i, input, 32: bus address; only addr_i[7:0] is decoded.
REQ-007 SHALL have port data_i, input, 32: bus write data.
REQ-008 SHALL have port data_o, output, 32: bus read data, combinational from addr_i.
REQ-009 SHALL have port io_pin_i, input, NUM_IO: raw pad inputs, asynchronous to clk.
REQ-010 SHALL have port io_out_o, output, NUM_IO: pad output data.
REQ-011 SHALL have port io_oe_o, output, NUM_IO: pad output enable, 1 = drive; the SoC top builds the tristate.
REQ-012 SHALL have port int_sig_o, output, 1: interrupt request, level, active-high.

Function
REQ-013 SHALL implement these registers: 0x00 DIR RW (1 = output); 0x04 OUT RW; 0x08 IN RO (synchronised pins); 0x0C IE RW; 0x10 ITYPE RW (0 = level, 1 = edge); 0x14 IPOL RW (1 = high/rising, 0 = low/falling); 0x18 IP RW1C; 0x1C OUTSET WO (OUT |= data_i); 0x20 OUTCLR WO (OUT &= ~data_i).
REQ-014 SHALL update a written register on the clk edge where we_i=1; the new value is visible on data_o in the next cycle.
REQ-015 SHALL read bits [31:NUM_IO] of every register as 0 and ignore writes to them.
REQ-016 SHALL return 0 on data_o for unmapped offsets and for the WO offsets; writes to unmapped offsets and to IN have no effect.
REQ-017 SHALL drive io_oe_o = DIR and io_out_o = OUT directly from registers.
REQ-018 SHALL pass each pin through SYNC_STAGES flops; IN reflects a pin change SYNC_STAGES cycles after it is sampled.
REQ-019 SHALL register the synchroniser output as prev each cycle; edge detect = sync != prev, qualified by IPOL; the IP bit sets one cycle after IN changes (SYNC_STAGES+1 after sampling).
REQ-020 SHALL make edge-mode IP bits sticky until cleared by writing 1 to the IP register.
REQ-021 SHALL resolve a same-cycle new edge and W1C clear on the same bit with set winning.
REQ-022 SHALL make level-mode IP bits track (sync == IPOL) every cycle, non-sticky, with W1C ignored.
REQ-023 SHALL set IP regardless of IE; int_sig_o = |(IP & IE), registered-free OR of register bits.
REQ-024 SHALL NOT set any IP bit in the same cycle that ITYPE or IPOL for that bit is written; evaluation resumes the next cycle.
REQ-025 SHALL still synchronise and detect edges on pins configured as outputs (loopback of the driven value).

Reset
REQ-026 SHALL asynchronously clear DIR, OUT, IE, ITYPE, IPOL, IP, the synchronisers and prev when rst=0 (all pins inputs, int_sig_o=0).
REQ-027 SHALL hold a warm-up counter that starts at reset release and gates edge detection off for SYNC_STAGES+1 cycles, so pins already high at reset cause no spurious edge.
REQ-028 SHALL abort any in-flight edge on reset assertion mid-operation, with no IP set after release from that edge.

Structure
REQ-029 SHALL place register offset constants (GPIO_DIR..GPIO_OUTCLR) in the shared core defines header.
REQ-030 SHALL use one sub-module, gpio_sync, parametrised by SYNC_STAGES: a one-bit synchroniser plus prev flop with sync and rise/fall outputs, instantiated NUM_IO times via generate.

Verification
REQ-031 SHALL cover: write DIR=0x00FF then OUT=0x00A5 -> io_oe_o=0x00FF and io_out_o=0x00A5 next cycle; write OUTSET=0x0100 -> OUT=0x01A5; write OUTCLR=0x0005 -> OUT=0x01A0.
REQ-032 SHALL cover: io_pin_i[3] 0->1 with ITYPE[3]=1, IPOL[3]=1, IE[3]=1 -> IN[3]=1 after 2 cycles, IP=0x0008 and int_sig_o=1 after 3 cycles; W1C 0x0008 -> IP=0.
REQ-033 SHALL cover: new edge on bit 3 in the same cycle as the W1C of bit 3 -> IP[3] remains 1.
REQ-034 SHALL cover: level-low on pin 5 (ITYPE=0, IPOL=0) with pin held 0 -> IP[5]=1; W1C has no effect; pin set 1 -> IP[5]=0 after 3 cycles.
REQ-035 SHALL cover: pins held 0xFFFF through reset release with all edge/rising config -> IP stays 0 for 10 cycles.
REQ-036 SHALL cover: NUM_IO=8 build, write 0xFFFFFFFF to DIR -> DIR reads 0x000000FF; read offset 0x24 -> 0.
